// File: rtl/temp_monitor_pkg.sv
// rtl/temp_monitor_pkg.sv - state encoding and seven-segment lookup shared by temp_monitor
package temp_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CONV,
    S_CAPT,
    S_BCD,
    S_UPD,
    S_ERR
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[digit];
  endfunction

endpackage

// File: rtl/temp_monitor_bin_to_bcd.sv
// rtl/temp_monitor_bin_to_bcd.sv - sequential double-dabble converter, one shift per cycle
module temp_monitor_bin_to_bcd #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    sh_bin;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CW-1:0]       bits_left;
  logic                busy;

  // Digits above DIGITS are simply dropped; the lower digits stay exact (value mod 10**DIGITS)
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bin    <= '0;
      bcd_r     <= '0;
      bits_left <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh_bin    <= bin;
        bcd_r     <= '0;
        bits_left <= CW'(BIN_W);
        busy      <= 1'b1;
      end else if (busy) begin
        {bcd_r, sh_bin} <= {bcd_adj[4*DIGITS-2:0], sh_bin, 1'b0};
        bits_left       <= bits_left - CW'(1);
        if (bits_left == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = bcd_r;

endmodule

// File: rtl/temp_monitor.sv
// rtl/temp_monitor.sv - periodic TSD sequencer with averaging, Celsius conversion, alarm and 7-seg output
module temp_monitor
  import temp_monitor_pkg::*;
#(
  parameter int TS_WIDTH    = 8,
  parameter int TS_OFFSET   = 128,
  parameter int AVG_LOG2    = 2,
  parameter int NUM_DIGITS  = 2,
  parameter int PERIOD_CYC  = 5_000_000,
  parameter int CLEAR_CYC   = 4,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int ALARM_HI    = 85,
  parameter int ALARM_LO    = 75
) (
  input  logic                    clk_50mhz,
  input  logic                    rst_50mhz_n,
  input  logic                    temp_valid,
  input  logic [TS_WIDTH-1:0]     temp_val,
  output logic                    temp_en,
  output logic                    temp_clear,
  output logic [TS_WIDTH-1:0]     temp_c,
  output logic                    temp_updated,
  output logic                    alarm,
  output logic                    timeout_err,
  output logic [7*NUM_DIGITS-1:0] hex_d,
  output logic [NUM_DIGITS-1:0]   hex_dp
);

  localparam int AW   = TS_WIDTH + AVG_LOG2;
  localparam int CNTW = AVG_LOG2 + 1;
  localparam int PW   = $clog2(PERIOD_CYC + 1);
  localparam int CLW  = $clog2(CLEAR_CYC + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int MAX_SHOWN = 10**NUM_DIGITS - 1;

  localparam logic [PW-1:0]       PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [CLW-1:0]      CLEAR_LAST  = CLW'(CLEAR_CYC - 1);
  localparam logic [TW-1:0]       TO_LAST     = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNTW-1:0]     CNT_LAST    = CNTW'((1 << AVG_LOG2) - 1);
  localparam logic [TS_WIDTH-1:0] OFFSET      = TS_WIDTH'(TS_OFFSET);
  localparam logic [TS_WIDTH-1:0] HI_C        = TS_WIDTH'(ALARM_HI);
  localparam logic [TS_WIDTH-1:0] LO_C        = TS_WIDTH'(ALARM_LO);

  state_t                    state, state_nxt;
  logic [PW-1:0]             period_cnt;
  logic [CLW-1:0]            clear_cnt;
  logic [TW-1:0]             to_cnt;
  logic [TS_WIDTH-1:0]       sample;
  logic [AW-1:0]             acc;
  logic [CNTW-1:0]           cnt;
  logic                      bcd_go;
  logic [4*NUM_DIGITS-1:0]   bcd;
  logic                      bcd_done;
  logic [TS_WIDTH-1:0]       avg;
  logic [TS_WIDTH-1:0]       c_val;
  logic                      clamp;
  logic                      ovf;
  logic [7*NUM_DIGITS-1:0]   hex_nxt;
  logic [NUM_DIGITS-1:0]     dp_nxt;

  always_ff @(posedge clk_50mhz or negedge rst_50mhz_n) begin
    if (!rst_50mhz_n) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    temp_en    = 1'b0;
    temp_clear = 1'b0;
    case (state)
      S_IDLE:  if (period_cnt == PERIOD_LAST) state_nxt = S_CLEAR;
      S_CLEAR: begin
        temp_clear = 1'b1;
        if (clear_cnt == CLEAR_LAST) state_nxt = S_CONV;
      end
      S_CONV: begin
        temp_en = 1'b1;
        if (temp_valid)             state_nxt = S_CAPT;
        else if (to_cnt == TO_LAST) state_nxt = S_ERR;
      end
      S_CAPT:  state_nxt = (cnt == CNT_LAST) ? S_BCD : S_IDLE;
      S_BCD:   if (bcd_done) state_nxt = S_UPD;
      S_UPD:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc already holds the final sum once BCD is entered, so c_val is stable there and in UPD
  always_comb begin
    avg     = TS_WIDTH'(acc >> AVG_LOG2);
    clamp   = avg < OFFSET;
    c_val   = clamp ? '0 : avg - OFFSET;
    ovf     = 32'(c_val) > 32'(MAX_SHOWN);
    hex_nxt = '1;
    dp_nxt  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_nxt[7*i +: 7] = ovf ? SEG_DIGIT[9] : seg_encode(bcd[4*i +: 4]);
    end
    if (ovf)        dp_nxt = '0;
    else if (clamp) dp_nxt[NUM_DIGITS-1] = 1'b0;
  end

  always_ff @(posedge clk_50mhz or negedge rst_50mhz_n) begin
    if (!rst_50mhz_n) begin
      period_cnt   <= PERIOD_LAST;
      clear_cnt    <= '0;
      to_cnt       <= '0;
      sample       <= '0;
      acc          <= '0;
      cnt          <= '0;
      bcd_go       <= 1'b0;
      temp_c       <= '0;
      temp_updated <= 1'b0;
      alarm        <= 1'b0;
      timeout_err  <= 1'b0;
      hex_d        <= '1;
      hex_dp       <= '1;
    end else begin
      temp_updated <= 1'b0;
      bcd_go       <= (state == S_CAPT) && (state_nxt == S_BCD);

      // Saturates so an over-long conversion starts the next one straight from IDLE
      if (state == S_IDLE && state_nxt == S_CLEAR) period_cnt <= '0;
      else if (period_cnt != PERIOD_LAST)          period_cnt <= period_cnt + PW'(1);

      clear_cnt <= (state == S_CLEAR) ? clear_cnt + CLW'(1) : '0;
      to_cnt    <= (state == S_CONV) ? to_cnt + TW'(1) : '0;
      if (state == S_CONV && temp_valid) sample <= temp_val;

      case (state)
        S_CAPT: begin
          acc <= acc + AW'(sample);
          cnt <= cnt + CNTW'(1);
        end
        S_UPD: begin
          temp_c       <= c_val;
          hex_d        <= hex_nxt;
          hex_dp       <= dp_nxt;
          temp_updated <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
          timeout_err  <= 1'b0;
          if (c_val >= HI_C)      alarm <= 1'b1;
          else if (c_val <= LO_C) alarm <= 1'b0;
        end
        S_ERR: begin
          timeout_err <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          hex_d       <= {NUM_DIGITS{SEG_DASH}};
          hex_dp      <= '1;
        end
        default: ;
      endcase
    end
  end

  temp_monitor_bin_to_bcd #(
    .BIN_W  (TS_WIDTH),
    .DIGITS (NUM_DIGITS)
  ) u_bin_to_bcd (
    .clk   (clk_50mhz),
    .rst_n (rst_50mhz_n),
    .start (bcd_go),
    .bin   (c_val),
    .bcd   (bcd),
    .done  (bcd_done)
  );

endmodule

// File: tb/tb_temp_monitor.sv
// tb/tb_temp_monitor.sv - self-checking bench for temp_monitor (two configurations)
module tb_temp_monitor;

  localparam int TIMEOUT = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tv_a = 1'b0, tv_b = 1'b0;
  logic [7:0] val_a = '0, val_b = '0;

  logic        en_a, clr_a, upd_a, alarm_a, to_a;
  logic [7:0]  c_a;
  logic [13:0] hex_a;
  logic [1:0]  dp_a;
  logic        en_b, clr_b, upd_b, alarm_b, to_b;
  logic [7:0]  c_b;
  logic [6:0]  hex_b;
  logic [0:0]  dp_b;

  int   n_checks = 0;
  int   n_pass = 0;
  int   upd_cnt_b = 0;
  logic alarm_m [2];
  logic [6:0] seg_ref [10];

  always #10 clk = ~clk;

  temp_monitor #(.AVG_LOG2(0), .NUM_DIGITS(2), .PERIOD_CYC(40), .CLEAR_CYC(4),
                 .TIMEOUT_CYC(TIMEOUT)) dut_a (
    .clk_50mhz(clk), .rst_50mhz_n(rst_n), .temp_valid(tv_a), .temp_val(val_a),
    .temp_en(en_a), .temp_clear(clr_a), .temp_c(c_a), .temp_updated(upd_a),
    .alarm(alarm_a), .timeout_err(to_a), .hex_d(hex_a), .hex_dp(dp_a));

  temp_monitor #(.AVG_LOG2(2), .NUM_DIGITS(1), .PERIOD_CYC(40), .CLEAR_CYC(4),
                 .TIMEOUT_CYC(TIMEOUT)) dut_b (
    .clk_50mhz(clk), .rst_50mhz_n(rst_n), .temp_valid(tv_b), .temp_val(val_b),
    .temp_en(en_b), .temp_clear(clr_b), .temp_c(c_b), .temp_updated(upd_b),
    .alarm(alarm_b), .timeout_err(to_b), .hex_d(hex_b), .hex_dp(dp_b));

  always @(posedge clk) if (upd_b === 1'b1) upd_cnt_b <= upd_cnt_b + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int celsius(int avg);
    return (avg < 128) ? 0 : avg - 128;
  endfunction

  function automatic logic [13:0] hex_ref(int avg, int nd);
    logic [13:0] h = '0;
    int c = celsius(avg);
    int lim = (nd == 1) ? 9 : 99;
    int div = 1;
    for (int i = 0; i < nd; i++) begin
      h[7*i +: 7] = (c > lim) ? seg_ref[9] : seg_ref[(c / div) % 10];
      div = div * 10;
    end
    return h;
  endfunction

  function automatic logic [1:0] dp_ref(int avg, int nd);
    logic [1:0] d = (nd == 1) ? 2'b01 : 2'b11;
    int lim = (nd == 1) ? 9 : 99;
    if (celsius(avg) > lim) d = '0;
    else if (avg < 128) d[nd-1] = 1'b0;
    return d;
  endfunction

  function automatic logic en_of(int sel);   return sel ? en_b : en_a;   endfunction
  function automatic logic clr_of(int sel);  return sel ? clr_b : clr_a; endfunction
  function automatic logic upd_of(int sel);  return sel ? upd_b : upd_a; endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] code);
    if (sel == 0) begin tv_a = v; val_a = code; end
    else          begin tv_b = v; val_b = code; end
  endtask

  // Waits for a fresh CLEAR, then answers the conversion; lat < 0 presets valid during CLEAR
  task automatic convert(input int sel, input logic [7:0] code, input int lat, output int en_cyc);
    int g = 0;
    en_cyc = 0;
    while (!clr_of(sel) && g < 300) begin @(negedge clk); g++; end
    check($sformatf("clear_seen_%0d", sel), clr_of(sel), 1);
    if (lat < 0) drive(sel, 1'b1, code);
    g = 0;
    while (!en_of(sel) && g < 50) begin @(negedge clk); g++; end
    check($sformatf("en_seen_%0d", sel), en_of(sel), 1);
    if (lat >= 0) begin
      repeat (lat) @(negedge clk);
      drive(sel, 1'b1, code);
    end
    while (en_of(sel) && en_cyc < 100) begin @(negedge clk); en_cyc++; end
    drive(sel, 1'b0, 8'h00);
  endtask

  task automatic expect_update(input int sel, input int avg);
    int g = 0;
    int c = celsius(avg);
    int nd = sel ? 1 : 2;
    string p = sel ? "b" : "a";
    if (c >= 85) alarm_m[sel] = 1'b1;
    else if (c <= 75) alarm_m[sel] = 1'b0;
    while (upd_of(sel) !== 1'b1 && g < 60) begin @(negedge clk); g++; end
    check({p, "_upd_seen"}, upd_of(sel), 1);
    check({p, "_temp_c"}, sel ? c_b : c_a, c);
    check({p, "_hex"}, sel ? {7'b0, hex_b} : hex_a, hex_ref(avg, nd));
    check({p, "_dp"}, sel ? {1'b0, dp_b} : dp_a, dp_ref(avg, nd));
    check({p, "_alarm"}, sel ? alarm_b : alarm_a, alarm_m[sel]);
    check({p, "_timeout_clr"}, sel ? to_b : to_a, 0);
    @(negedge clk);
    check({p, "_upd_width"}, upd_of(sel), 0);
  endtask

  task automatic check_reset_vals;
    check("rst_a_en", en_a, 0);        check("rst_a_clear", clr_a, 0);
    check("rst_a_temp_c", c_a, 0);     check("rst_a_upd", upd_a, 0);
    check("rst_a_alarm", alarm_a, 0);  check("rst_a_timeout", to_a, 0);
    check("rst_a_hex", hex_a, 14'h3FFF); check("rst_a_dp", dp_a, 2'b11);
    check("rst_b_temp_c", c_b, 0);     check("rst_b_hex", hex_b, 7'h7F);
    check("rst_b_en", en_b, 0);        check("rst_b_dp", dp_b, 1'b1);
  endtask

  initial begin
    int ec, n, k, g, sum;
    logic [7:0] code;
    logic [7:0] alarm_codes [4];
    seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    alarm_codes = '{8'd208, 8'd203, 8'd202, 8'd230};
    alarm_m = '{1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    check("a_clear_first_edge", clr_a, 1);
    check("b_clear_first_edge", clr_b, 1);
    n = 0;
    while (clr_a && n < 20) begin
      check("a_en_clear_excl", en_a & clr_a, 0);
      n++;
      @(negedge clk);
    end
    check("a_clear_len", n, 4);
    check("a_en_after_clear", en_a, 1);

    convert(0, 8'hA5, 2, ec);
    expect_update(0, 8'hA5);
    check("a_37_temp_c", c_a, 37);
    check("a_37_hex", hex_a, {7'b0110000, 7'b1111000});

    convert(0, 8'h10, 5, ec);
    expect_update(0, 8'h10);
    check("a_clamp_hex", hex_a, {7'b1000000, 7'b1000000});
    check("a_clamp_dp", dp_a, 2'b01);

    convert(0, 8'd240, 0, ec);
    expect_update(0, 240);

    g = 0;
    while (!en_a && g < 300) begin @(negedge clk); g++; end
    k = 0;
    while (!to_a && k < 100) begin @(negedge clk); k++; end
    check("a_timeout_latency", k, TIMEOUT + 1);
    check("a_timeout_err", to_a, 1);
    check("a_timeout_dashes", hex_a, {7'b0111111, 7'b0111111});
    check("a_timeout_temp_c_hold", c_a, 112);
    check("a_timeout_alarm_hold", alarm_a, alarm_m[0]);

    convert(0, 8'd213, -1, ec);
    check("a_first_cycle_accept", ec, 1);
    expect_update(0, 213);
    check("a_alarm_set_85", alarm_a, 1);
    for (int i = 0; i < 4; i++) begin
      convert(0, alarm_codes[i], int'($urandom_range(0, 10)), ec);
      expect_update(0, alarm_codes[i]);
    end

    g = 0;
    while (!en_a && g < 300) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    alarm_m = '{1'b0, 1'b0};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("a_restart_clear", clr_a, 1);
    check("b_restart_clear", clr_b, 1);

    for (int i = 0; i < 10; i++) begin
      code = 8'($urandom_range(0, 255));
      convert(0, code, int'($urandom_range(0, 10)), ec);
      expect_update(0, code);
    end

    n = upd_cnt_b;
    for (int i = 0; i < 4; i++) begin
      convert(1, 8'(200 + i), int'($urandom_range(0, 10)), ec);
      if (i < 3) check("b_no_early_upd", upd_cnt_b, n);
    end
    expect_update(1, 201);
    check("b_one_upd_per_group", upd_cnt_b, n + 1);
    check("b_avg_temp_c", c_b, 73);

    for (int i = 0; i < 4; i++) convert(1, 8'hA5, int'($urandom_range(0, 10)), ec);
    expect_update(1, 165);
    check("b_ovf_hex", hex_b, 7'b0010000);
    check("b_ovf_dp", dp_b, 1'b0);

    for (int r = 0; r < 2; r++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        code = 8'($urandom_range(100, 140));
        sum += code;
        convert(1, code, int'($urandom_range(0, 10)), ec);
      end
      expect_update(1, sum / 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
